// File: rtl/rom_ram_loader.sv
// rom_ram_loader: bus initiator that copies 16-bit ROM words into byte-wide RAM, low byte first.
// Define ROM_RAM_LOADER_VERIFY_EN to add a read-back check after every byte written.
module rom_ram_loader #(
   parameter int bus_addr_pgm_width  = 11,
   parameter int bus_addr_data_width = 13
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [bus_addr_pgm_width-1:0]  src_a,
   input  logic [bus_addr_data_width-1:0] dst_a,
   input  logic [bus_addr_data_width:0]   len,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [bus_addr_pgm_width-1:0]  pmem_a,
   input  logic [15:0]                    pmem_d,
   output logic                           dmem_we,
   output logic                           dmem_re,
   output logic [bus_addr_data_width-1:0] dmem_a,
   output logic [7:0]                     dmem_w,
   input  logic [7:0]                     dmem_r
);
   localparam int PW = bus_addr_pgm_width;
   localparam int DW = bus_addr_data_width;
   localparam logic [PW-1:0] SRC_ONE  = PW'(1'b1);
   localparam logic [DW-1:0] DST_ONE  = DW'(1'b1);
   localparam logic [DW:0]   CNT_ONE  = (DW+1)'(1'b1);
   localparam logic [DW:0]   CNT_ZERO = (DW+1)'(1'b0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_LO  = 3'd1,
      WR_HI  = 3'd2,
      CHK_LO = 3'd3,
      CHK_HI = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t         state_r, state_s;
   logic [PW-1:0]  src_r, src_s;
   logic [DW-1:0]  dst_r, dst_s;
   logic [DW:0]    cnt_r, cnt_s;
`ifdef ROM_RAM_LOADER_VERIFY_EN
   logic           err_r, err_s;
   logic [7:0]     exp_r, exp_s;
`else
   logic           unused_s;
   assign unused_s = ^dmem_r;
`endif

   // Next-state and working-pointer update.
   always_comb begin
      state_s = state_r;
      src_s   = src_r;
      dst_s   = dst_r;
      cnt_s   = cnt_r;
`ifdef ROM_RAM_LOADER_VERIFY_EN
      err_s   = err_r;
      exp_s   = exp_r;
`endif
      case (state_r)
         IDLE: begin
            if (start) begin
               src_s = src_a;
               dst_s = dst_a;
               cnt_s = len;
`ifdef ROM_RAM_LOADER_VERIFY_EN
               err_s = 1'b0;
`endif
               if (len == CNT_ZERO) begin
                  state_s = DONE;
               end else begin
                  state_s = WR_LO;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WR_LO: begin
            dst_s = dst_r + DST_ONE;
            cnt_s = cnt_r - CNT_ONE;
`ifdef ROM_RAM_LOADER_VERIFY_EN
            exp_s   = pmem_d[7:0];
            state_s = CHK_LO;
`else
            if (cnt_r == CNT_ONE) begin
               state_s = DONE;
            end else begin
               state_s = WR_HI;
            end
`endif
         end
         WR_HI: begin
            dst_s = dst_r + DST_ONE;
            cnt_s = cnt_r - CNT_ONE;
            src_s = src_r + SRC_ONE;
`ifdef ROM_RAM_LOADER_VERIFY_EN
            exp_s   = pmem_d[15:8];
            state_s = CHK_HI;
`else
            if (cnt_r == CNT_ONE) begin
               state_s = DONE;
            end else begin
               state_s = WR_LO;
            end
`endif
         end
`ifdef ROM_RAM_LOADER_VERIFY_EN
         // cnt already counts the byte under check, so zero means it was the last one.
         CHK_LO: begin
            if (dmem_r != exp_r) begin
               err_s   = 1'b1;
               state_s = DONE;
            end else if (cnt_r == CNT_ZERO) begin
               state_s = DONE;
            end else begin
               state_s = WR_HI;
            end
         end
         CHK_HI: begin
            if (dmem_r != exp_r) begin
               err_s   = 1'b1;
               state_s = DONE;
            end else if (cnt_r == CNT_ZERO) begin
               state_s = DONE;
            end else begin
               state_s = WR_LO;
            end
         end
`endif
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output decode from registered state; only pmem_d reaches dmem_w combinationally.
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      dmem_we = 1'b0;
      dmem_re = 1'b0;
      dmem_a  = {DW{1'b0}};
      dmem_w  = 8'h00;
      case (state_r)
         WR_LO: begin
            busy    = 1'b1;
            dmem_we = !rst;
            dmem_a  = dst_r;
            dmem_w  = pmem_d[7:0];
         end
         WR_HI: begin
            busy    = 1'b1;
            dmem_we = !rst;
            dmem_a  = dst_r;
            dmem_w  = pmem_d[15:8];
         end
`ifdef ROM_RAM_LOADER_VERIFY_EN
         CHK_LO, CHK_HI: begin
            busy    = 1'b1;
            dmem_re = !rst;
            dmem_a  = dst_r - DST_ONE;
         end
`endif
         DONE:    done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign pmem_a = src_r;
`ifdef ROM_RAM_LOADER_VERIFY_EN
   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   // State and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         src_r   <= {PW{1'b0}};
         dst_r   <= {DW{1'b0}};
         cnt_r   <= CNT_ZERO;
`ifdef ROM_RAM_LOADER_VERIFY_EN
         err_r   <= 1'b0;
         exp_r   <= 8'h00;
`endif
      end else begin
         state_r <= state_s;
         src_r   <= src_s;
         dst_r   <= dst_s;
         cnt_r   <= cnt_s;
`ifdef ROM_RAM_LOADER_VERIFY_EN
         err_r   <= err_s;
         exp_r   <= exp_s;
`endif
      end
   end

endmodule

// File: tb/tb_rom_ram_loader.sv
// Self-checking bench for rom_ram_loader: vector table, corner-case sequences and random transfers
// compared against a byte-level copy model (ROM word i/2, low byte on even i, RAM address dst+i).
module tb_rom_ram_loader;
`ifdef ROM_RAM_LOADER_VERIFY_EN
   localparam int CPB = 2;
`else
   localparam int CPB = 1;
`endif

   logic        clk = 1'b0;
   logic        rst, start;
   logic [10:0] src_a;
   logic [12:0] dst_a;
   logic [13:0] len;
   logic        busy, done, err, dmem_we, dmem_re;
   logic [10:0] pmem_a;
   logic [15:0] pmem_d;
   logic [12:0] dmem_a;
   logic [7:0]  dmem_w, dmem_r;

   logic [15:0] rom [0:2047];
   logic [7:0]  ram [0:8191];
   logic        corrupt_en;
   logic [12:0] corrupt_addr;

   typedef struct packed { logic [12:0] a; logic [7:0] b; } wr_t;
   wr_t wr_q[$];
   int  busy_cnt, done_cnt, done_cyc, start_cyc;
   int  cyc = 0;
   logic first_we;
   int  n_cmp = 0, n_bad = 0;

   typedef struct {
      logic [10:0] src;
      logic [12:0] dst;
      logic [13:0] len;
      int          exp_wr;
      logic [10:0] exp_pa;
   } vec_t;
   vec_t vecs [7];

   rom_ram_loader dut (
      .clk(clk), .rst(rst), .start(start), .src_a(src_a), .dst_a(dst_a), .len(len),
      .busy(busy), .done(done), .err(err), .pmem_a(pmem_a), .pmem_d(pmem_d),
      .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_a(dmem_a), .dmem_w(dmem_w), .dmem_r(dmem_r)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign pmem_d = rom[pmem_a];
   assign dmem_r = dmem_re ? (ram[dmem_a] ^ ((corrupt_en && dmem_a == corrupt_addr) ? 8'hFF : 8'h00))
                           : 8'h00;

   // RAM model and activity monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (dmem_we) begin
            wr_q.push_back({dmem_a, dmem_w});
            ram[dmem_a] = dmem_w;
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic begin_xfer(input logic [10:0] s, input logic [12:0] d, input logic [13:0] l);
      wr_q.delete();
      busy_cnt = 0; done_cnt = 0; done_cyc = -1;
      src_a = s; dst_a = d; len = l; start = 1'b1;
      @(posedge clk); #1;
      start_cyc = cyc;
      first_we  = dmem_we;
      start = 1'b0;
      src_a = 11'($urandom); dst_a = 13'($urandom); len = 14'($urandom);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_cnt != 0) break;
      end
   endtask

   // Compare one finished transfer against the copy model; called in the DONE cycle.
   task automatic check_xfer(input string name, input logic [10:0] s, input logic [12:0] d,
                             input int exp_wr, input logic [10:0] exp_pa, input logic exp_err);
      int bad;
      bad = 0;
      chk({name, ".done_cnt"}, done_cnt, 1);
      chk({name, ".done_lat"}, done_cyc - start_cyc, exp_wr * CPB);
      chk({name, ".n_writes"}, wr_q.size(), exp_wr);
      chk({name, ".busy_cyc"}, busy_cnt, exp_wr * CPB);
      chk({name, ".first_we"}, first_we, (exp_wr > 0) ? 1 : 0);
      chk({name, ".pmem_a"}, pmem_a, exp_pa);
      chk({name, ".err"}, err, exp_err);
      chk({name, ".busy_in_done"}, busy, 0);
      for (int i = 0; i < exp_wr && i < wr_q.size(); i++) begin
         logic [15:0] w;
         logic [7:0]  eb;
         logic [12:0] ea;
         w  = rom[11'(s + i / 2)];
         eb = (i % 2 == 0) ? w[7:0] : w[15:8];
         ea = 13'(d + i);
         if (wr_q[i].a !== ea || wr_q[i].b !== eb) bad++;
      end
      chk({name, ".bytes_bad"}, bad, 0);
   endtask

   task automatic xfer(input string name, input logic [10:0] s, input logic [12:0] d,
                       input logic [13:0] l, input int exp_wr, input logic [10:0] exp_pa);
      begin_xfer(s, d, l);
      wait_done(int'(l) * CPB + 16);
      check_xfer(name, s, d, exp_wr, exp_pa, 1'b0);
      step();
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, ".busy"}, busy, 0);
      chk({name, ".done"}, done, 0);
      chk({name, ".err"}, err, 0);
      chk({name, ".we"}, dmem_we, 0);
      chk({name, ".re"}, dmem_re, 0);
      chk({name, ".pmem_a"}, pmem_a, 0);
      chk({name, ".dmem_a"}, dmem_a, 0);
      chk({name, ".dmem_w"}, dmem_w, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; src_a = 11'h000; dst_a = 13'h0000; len = 14'd0;
      corrupt_en = 1'b0; corrupt_addr = 13'h0000;
      busy_cnt = 0; done_cnt = 0; done_cyc = -1; start_cyc = 0; first_we = 1'b0;
      for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
      for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
      rom[11'h010] = 16'hBEEF;
      rom[11'h011] = 16'h1234;

      vecs[0] = '{11'h010, 13'h0100, 14'd4,    4,    11'h012};
      vecs[1] = '{11'h010, 13'h0100, 14'd3,    3,    11'h011};
      vecs[2] = '{11'h123, 13'h0456, 14'd0,    0,    11'h123};
      vecs[3] = '{11'h7FF, 13'h1FFF, 14'd2,    2,    11'h000};
      vecs[4] = '{11'h7FF, 13'h1FFE, 14'd5,    5,    11'h001};
      vecs[5] = '{11'h000, 13'h00AB, 14'd8192, 8192, 11'h000};
      vecs[6] = '{11'h400, 13'h0000, 14'd1,    1,    11'h400};

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      for (int i = 0; i < 7; i++) begin
         if (i == 1) ram[13'h0103] = 8'h5A;
         xfer($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].exp_wr, vecs[i].exp_pa);
         if (i == 0) begin
            chk("vec0.ram100", ram[13'h0100], 8'hEF);
            chk("vec0.ram101", ram[13'h0101], 8'hBE);
            chk("vec0.ram102", ram[13'h0102], 8'h34);
            chk("vec0.ram103", ram[13'h0103], 8'h12);
         end
         if (i == 1) chk("vec1.ram103_kept", ram[13'h0103], 8'h5A);
      end

      // start while busy must not disturb the latched transfer
      begin_xfer(11'h010, 13'h0200, 14'd4);
      step();
      start = 1'b1; len = 14'd1; dst_a = 13'h0000; src_a = 11'h055;
      step();
      start = 1'b0;
      wait_done(4 * CPB + 16);
      check_xfer("busy_start", 11'h010, 13'h0200, 4, 11'h012, 1'b0);
      step();

      // start held during DONE is ignored
      begin_xfer(11'h300, 13'h0800, 14'd1);
      wait_done(CPB + 16);
      check_xfer("done_start", 11'h300, 13'h0800, 1, 11'h300, 1'b0);
      start = 1'b1; src_a = 11'h0AA; dst_a = 13'h0AAA; len = 14'd9;
      step();
      chk("done_start.busy_after", busy, 0);
      chk("done_start.we_after", dmem_we, 0);
      start = 1'b0;
      step();
      chk("done_start.idle_busy", busy, 0);
      chk("done_start.pmem_a_kept", pmem_a, 11'h300);

      // reset asserted in the third cycle of a len=8 transfer
      begin_xfer(11'h020, 13'h0300, 14'd8);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rst_mid.we_gated", dmem_we, 0);
      step();
      chk_all_zero("rst_mid");
      rst = 1'b0;
      step();
      step();
      chk("rst_mid.n_writes", wr_q.size(), (CPB == 1) ? 2 : 1);
      chk("rst_mid.no_done", done_cnt, 0);
      xfer("after_rst", 11'h020, 13'h0300, 14'd8, 8, 11'h024);

`ifdef ROM_RAM_LOADER_VERIFY_EN
      // byte 2 reads back wrong: abort after its check with err set
      corrupt_en = 1'b1;
      corrupt_addr = 13'h0402;
      begin_xfer(11'h050, 13'h0400, 14'd6);
      wait_done(6 * CPB + 16);
      check_xfer("verify_err", 11'h050, 13'h0400, 3, 11'h051, 1'b1);
      step();
      chk("verify_err.sticky", err, 1);
      corrupt_en = 1'b0;
      begin_xfer(11'h050, 13'h0400, 14'd6);
      chk("verify_err.cleared", err, 0);
      wait_done(6 * CPB + 16);
      check_xfer("verify_ok", 11'h050, 13'h0400, 6, 11'h053, 1'b0);
      step();
`endif

      for (int k = 0; k < 25; k++) begin
         logic [10:0] s;
         logic [12:0] d;
         logic [13:0] l;
         s = 11'($urandom_range(0, 2047));
         d = 13'($urandom_range(0, 8191));
         l = ($urandom_range(0, 5) == 0) ? 14'd0 : 14'($urandom_range(1, 40));
         xfer($sformatf("rnd%0d", k), s, d, l, int'(l), 11'(s + l / 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rom_ram_loader.md
# rom_ram_loader

Memory-bus initiator that copies a block of 16-bit program-memory words into byte-wide data RAM, driving the ROM port (`pmem_a`/`pmem_d`) and the RAM port (`dmem_*`) from the master side. It sits beside the XMEGA core and runs its transfer at boot to initialise the `.data` section, or later under software control. A transfer is started by a `start` pulse and ends with a `done` pulse. It can optionally read back and check every byte it writes.

## Interface
- `bus_addr_pgm_width`, 11, ROM word-address width
- `bus_addr_data_width`, 13, RAM byte-address width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a transfer; sampled only in IDLE
- `src_a`  in  bus_addr_pgm_width  first ROM word address
- `dst_a`  in  bus_addr_data_width  first RAM byte address
- `len`  in  bus_addr_data_width+1  byte count, 0..2^bus_addr_data_width
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky verify mismatch; cleared by the next accepted `start` or by `rst`
- `pmem_a`  out  bus_addr_pgm_width  ROM word address
- `pmem_d`  in  16  ROM data; combinational from `pmem_a`
- `dmem_we`  out  1  RAM write strobe
- `dmem_re`  out  1  RAM read enable (RAM output is high-Z when 0)
- `dmem_a`  out  bus_addr_data_width  RAM byte address
- `dmem_w`  out  8  RAM write data
- `dmem_r`  in  8  RAM read data

## Operation
- States: IDLE, WR_LO, WR_HI, CHK_LO, CHK_HI, DONE. The CHK states exist only with verify compiled in.
- IDLE with `start=1`:
  - Latch `src_a`, `dst_a` and `len` into the working pointers and the remaining count `cnt`.
  - Clear `err`.
  - If `len=0`, go to DONE. Otherwise go to WR_LO.
- Byte order is little-endian: the low byte `pmem_d[7:0]` is written first, then the high byte `pmem_d[15:8]`.
- WR_LO:
  - Drive `dmem_we=1`, `dmem_a=dst`, `dmem_w=pmem_d[7:0]`.
  - `dst` increments and `cnt` decrements.
  - Next state: CHK_LO if verify is built in; otherwise DONE if `cnt` was 1, else WR_HI.
- WR_HI:
  - Same as WR_LO but writes `pmem_d[15:8]`.
  - `src` increments after the high byte.
  - Next state: CHK_HI if verify is built in; otherwise DONE if `cnt` was 1, else WR_LO.
- An odd `len` ends after a low byte. The unused high byte is never written.
- `pmem_a` equals `src` in every state.
- Address arithmetic:
  - `dst` wraps modulo 2^bus_addr_data_width.
  - `src` wraps modulo 2^bus_addr_pgm_width.
  - `len` = 2^bus_addr_data_width is legal and fills the whole RAM exactly once.
- DONE: assert `done` for one cycle, then return to IDLE.
- `start` is ignored while `busy=1` and in DONE.
- IDLE outputs: `dmem_we=0`, `dmem_re=0`. `dmem_a` and `dmem_w` are don't-care but driven to 0.

## Timing
- Reset values: `busy=0`, `done=0`, `err=0`, `dmem_we=0`, `dmem_re=0`, `pmem_a=0`, `dmem_a=0`, `dmem_w=0`. State is IDLE.
- `dmem_we` and `dmem_re` are gated by `!rst`, so no RAM access occurs in a reset cycle.
- Reset mid-transfer:
  - Abort immediately and return to IDLE.
  - No `done` pulse is produced.
  - Bytes already written are left in RAM.
- All outputs are decoded from registered state. The only combinational input-to-output path is `pmem_d` to `dmem_w`.
- `start` accepted at edge N:
  - The first write strobe is high during cycle N+1.
  - The RAM captures that byte at edge N+2.
- Throughput:
  - Without verify, one byte per cycle. `len=L` takes L write cycles, and `done` is high in cycle N+1+L.
  - With verify, two cycles per byte, and `done` is high in cycle N+1+2L.
- `len=0`: `done` is high in cycle N+1 and no `dmem_we` is asserted.
- `busy` is high from cycle N+1 through the last write or check cycle. It is low during DONE.

## Configuration
- Macro: `ROM_RAM_LOADER_VERIFY_EN`.
- Defined:
  - After each write state, the matching CHK state drives `dmem_re=1`, `dmem_we=0` and `dmem_a` = the address just written.
  - It compares `dmem_r` with the expected byte.
  - On a mismatch, set `err=1` and go to DONE, aborting the transfer. On a match, continue.
- Not defined:
  - The CHK states and the compare logic are absent.
  - `dmem_re` is tied to 0 and `err` is tied to 0.

## Test plan
- `src_a=0x010`, `dst_a=0x0100`, `len=4`, ROM[0x010]=0xBEEF, ROM[0x011]=0x1234 -> RAM[0x100..0x103] = EF, BE, 34, 12. `done` is high in cycle N+5; `busy` is high for 4 cycles.
- `len=3` with the same data -> RAM[0x103] is untouched and there are exactly 3 `dmem_we` pulses.
- `len=0` -> `done` is high in cycle N+1 with no writes. `start` asserted while `busy=1` -> ignored, and the latched `len` is unchanged.
- `dst_a`=0x1FFF, `len=2`, `src_a`=0x7FF -> writes go to 0x1FFF and then 0x0000, and `pmem_a` wraps to 0x000 after the word.
- Assert `rst` in the third write cycle of a `len=8` transfer -> only 2 bytes are written, no `done` pulse, all outputs are 0, and a new `start` works normally.
- `ROM_RAM_LOADER_VERIFY_EN` defined, RAM model forces byte 2 to read back wrong -> `err=1` and `done` pulses after CHK of byte 2. The next `start` clears `err`.
